// File: rtl/piso_encoder.sv
// Parallel-in serial-out encoder: accepts a message over valid/ready and shifts it out LSB first.
// Optional build macro PARITY_EN appends an even-parity bit after the MSB of every frame.
module piso_encoder #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] message,
    input  logic                  messageValid,
    output logic                  messageReady,
    output logic                  serialOut,
    output logic                  frameStart,
    output logic                  busy
);

`ifdef PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_WIDTH-1:0] m);
`ifdef PARITY_EN
        return {^m, m};
`else
        return m;
`endif
    endfunction

    logic [0:0]           state_p0;
    logic [CNT_W-1:0]     cnt_p0;
    logic [FRAME_LEN-1:0] shreg_p0;
    logic                 out_p0;
    logic                 start_p0;
    logic                 busy_p0;

    logic                 last_bit;
    logic                 load;
    logic [FRAME_LEN-1:0] next_frame;

    // Ready on the last bit as well as in IDLE so frames can stream with no gap.
    assign last_bit     = (state_p0 == SHIFT) && (cnt_p0 == LAST_CNT);
    assign messageReady = (state_p0 == IDLE) || last_bit;
    assign load         = messageReady && messageValid;
    assign next_frame   = build_frame(message);

    // Stage p0: out_p0 always mirrors shreg_p0[0] while a frame is active.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            shreg_p0 <= '0;
            out_p0   <= IDLE_BIT;
            start_p0 <= 1'b0;
            busy_p0  <= 1'b0;
        end else if (load) begin
            state_p0 <= SHIFT;
            cnt_p0   <= '0;
            shreg_p0 <= next_frame;
            out_p0   <= next_frame[0];
            start_p0 <= 1'b1;
            busy_p0  <= 1'b1;
        end else if (last_bit) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            shreg_p0 <= '0;
            out_p0   <= IDLE_BIT;
            start_p0 <= 1'b0;
            busy_p0  <= 1'b0;
        end else if (state_p0 == SHIFT) begin
            cnt_p0   <= cnt_p0 + 1'b1;
            shreg_p0 <= shreg_p0 >> 1;
            out_p0   <= shreg_p0[1];
            start_p0 <= 1'b0;
        end
    end

    assign serialOut  = out_p0;
    assign frameStart = start_p0;
    assign busy       = busy_p0;

endmodule

// File: tb/tb_piso_encoder.sv
// Directed bench for piso_encoder: single frame, streaming, held-input changes, mid-frame reset, random streaming.
module tb_piso_encoder;

`ifdef PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam logic IDLE_BIT = 1'b0;

    logic       clock;
    logic       reset;
    logic [7:0] message;
    logic       messageValid;
    logic       messageReady;
    logic       serialOut;
    logic       frameStart;
    logic       busy;

    int total = 0;
    int bad   = 0;

    piso_encoder #(.DATA_WIDTH(8), .IDLE_BIT(IDLE_BIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .message      (message),
        .messageValid (messageValid),
        .messageReady (messageReady),
        .serialOut    (serialOut),
        .frameStart   (frameStart),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] m, input int b);
        if (b < 8) return m[b];
        return ^m;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_idle_out"}, serialOut, IDLE_BIT);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_start"}, frameStart, 1'b0);
        chk({tag, "_idle_ready"}, messageReady, 1'b1);
    endtask

    // Caller has already presented m with messageValid=1; the first step is the accepting edge.
    task automatic expect_frame(input string tag, input logic [7:0] m, input int chg_at,
                                input logic [7:0] nxt, input logic stop);
        logic [7:0] rx;
        rx = 8'h00;
        for (int b = 0; b < FL; b++) begin
            step();
            chk({tag, "_bit"}, serialOut, frame_bit(m, b));
            chk({tag, "_start"}, frameStart, (b == 0));
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_ready"}, messageReady, (b == FL - 1));
            if (b < 8) rx[b] = serialOut;
            if (b == chg_at) message = nxt;
            if (b == FL - 1 && stop) messageValid = 1'b0;
        end
        chk({tag, "_rxword"}, rx, m);
        if (stop) begin
            step();
            check_idle(tag);
        end
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] nx;

        reset        = 1'b1;
        message      = 8'h00;
        messageValid = 1'b0;
        #1;
        check_idle("rst");
        step();
        step();
        reset = 1'b0;
        step();
        check_idle("post_rst");

        // single frame of 8'hA5
        message      = 8'hA5;
        messageValid = 1'b1;
        chk("t1_ready_pre", messageReady, 1'b1);
        expect_frame("t1", 8'hA5, -1, 8'h00, 1'b1);

        // zero-gap streaming
        message      = 8'h01;
        messageValid = 1'b1;
        expect_frame("t2a", 8'h01, FL - 1, 8'hFF, 1'b0);
        expect_frame("t2b", 8'hFF, FL - 1, 8'h80, 1'b0);
        expect_frame("t2c", 8'h80, -1, 8'h00, 1'b1);

        // message changed while not ready must not disturb the frame in flight
        message      = 8'h3C;
        messageValid = 1'b1;
        expect_frame("t3a", 8'h3C, FL - 2, 8'hC3, 1'b0);
        expect_frame("t3b", 8'hC3, -1, 8'h00, 1'b1);

        // async reset at bit 4 of 8'hF0
        message      = 8'hF0;
        messageValid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            step();
            chk("t4_bit", serialOut, frame_bit(8'hF0, b));
            if (b == 0) messageValid = 1'b0;
        end
        chk("t4_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_idle("t4_rst");
        step();
        check_idle("t4_rst_hold");
        reset = 1'b0;
        step();
        check_idle("t4_rel");
        message      = 8'h5A;
        messageValid = 1'b1;
        expect_frame("t4_after", 8'h5A, -1, 8'h00, 1'b1);

`ifdef PARITY_EN
        // parity frames: 8'h07 -> parity 1, 8'h03 -> parity 0
        message      = 8'h07;
        messageValid = 1'b1;
        expect_frame("t5a", 8'h07, FL - 1, 8'h03, 1'b0);
        expect_frame("t5b", 8'h03, -1, 8'h00, 1'b1);
`endif

        // 256 random messages streamed back to back
        cur          = 8'($urandom_range(0, 255));
        message      = cur;
        messageValid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            nx = 8'($urandom_range(0, 255));
            expect_frame("t6", cur, (i == 255) ? -1 : FL - 1, nx, (i == 255));
            cur = nx;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
